// File: rtl/serial_adder.sv
// Bit-serial (digit-serial) unsigned adder: computes {carry,sum} = a+b+cin
// DIGIT bits per cycle over N = WIDTH/DIGIT busy cycles, with valid/ready handshakes.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int N  = (DIGIT > 0) ? WIDTH / DIGIT : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || WIDTH > 64 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("serial_adder: WIDTH must be 1..64 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cy_q;
    logic [CW-1:0]    cnt_q;

    logic [DIGIT:0]   chunk;
    logic [WIDTH-1:0] chunk_hi;
    logic             last_chunk;

    always_comb begin
        chunk      = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, cy_q};
        // Result digit lands at the MSB end so the full sum is aligned after N shifts.
        chunk_hi   = WIDTH'(chunk[DIGIT-1:0]) << (WIDTH - DIGIT);
        last_chunk = (cnt_q == CW'(N - 1));
    end

    // Output carry is a separate register so it only moves at the end of BUSY,
    // not when cin is loaded into the working carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            cy_q      <= 1'b0;
            cnt_q     <= '0;
            sum       <= '0;
            carry     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        cy_q     <= cin;
                        cnt_q    <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                    end
                end
                BUSY: begin
                    a_q   <= a_q >> DIGIT;
                    b_q   <= b_q >> DIGIT;
                    cy_q  <= chunk[DIGIT];
                    sum   <= (sum >> DIGIT) | chunk_hi;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_chunk) begin
                        carry     <= chunk[DIGIT];
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
- REQ-001 The module SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal range 1..64).
- REQ-002 The module SHALL have parameter DIGIT, default 1, meaning bits added per cycle; WIDTH mod DIGIT SHALL equal 0, and elaboration SHALL fail otherwise.
- REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
- REQ-004 rst_n  input  1  asynchronous, active-low reset.
- REQ-005 in_valid  input  1  operands a, b and cin are valid.
- REQ-006 in_ready  output  1  block can accept operands.
- REQ-007 a  input  WIDTH  operand A, unsigned.
- REQ-008 b  input  WIDTH  operand B, unsigned.
- REQ-009 cin  input  1  carry-in.
- REQ-010 out_valid  output  1  sum and carry hold a completed result.
- REQ-011 out_ready  input  1  consumer accepts the result.
- REQ-012 sum  output  WIDTH  low WIDTH bits of a+b+cin.
- REQ-013 carry  output  1  bit WIDTH of a+b+cin.

Function
- REQ-014 The module SHALL define N = WIDTH/DIGIT as the number of compute cycles per operation.
- REQ-015 The FSM SHALL have three states: IDLE, BUSY and DONE.
- REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both are registered-state decodes with no combinational path from in_valid or out_ready.
- REQ-017 IDLE with in_valid=1 on an edge SHALL capture a, b and cin into internal shift registers, clear the chunk counter, and go to BUSY.
- REQ-018 IDLE with in_valid=0 SHALL stay in IDLE; a, b and cin SHALL be ignored whenever in_ready=0.
- REQ-019 Each BUSY cycle SHALL add the DIGIT LSBs of the A and B shift registers plus the carry register, and SHALL shift the DIGIT-bit result into the MSB end of the sum register.
- REQ-020 In each BUSY cycle, the carry register SHALL take the chunk carry-out, and the A/B registers SHALL shift right by DIGIT.
- REQ-021 BUSY SHALL last exactly N cycles; on the edge that processes chunk N-1, the FSM SHALL go to DONE.
- REQ-022 Latency: out_valid SHALL rise exactly N clock edges after the accept edge.
- REQ-023 In DONE, sum and carry SHALL hold stable until the handshake out_valid=1 and out_ready=1 on an edge; the FSM SHALL then go to IDLE.
- REQ-024 out_ready held at 0 SHALL stall DONE indefinitely, with no loss or change of the result.
- REQ-025 sum and carry SHALL keep the last result after returning to IDLE, and SHALL change only during the next BUSY phase.
- REQ-026 Minimum operation period SHALL be N+2 cycles: accept, N busy cycles, DONE, IDLE.
- REQ-027 Arithmetic SHALL be unsigned modulo 2^(WIDTH+1), with {carry,sum} == a+b+cin for all inputs, including all-ones operands with cin=1.
- REQ-028 For DIGIT == WIDTH, there SHALL be one BUSY cycle (N=1).
- REQ-029 out_ready asserted outside DONE SHALL have no effect.

Reset
- REQ-030 On rst_n=0, the module SHALL immediately, without waiting for clk, force: state IDLE, in_ready=1, out_valid=0, sum=0, carry=0, internal registers and counter 0.
- REQ-031 Reset asserted in BUSY or DONE SHALL abort the operation and discard the result; no out_valid pulse SHALL follow reset release.
- REQ-032 After rst_n deasserts, the first rising edge SHALL be able to accept operands.

Verification
- REQ-033 Reset check: assert rst_n=0 mid-BUSY (WIDTH=8, DIGIT=1, after 3 busy cycles) -> out_valid=0, in_ready=1, sum=0, carry=0 with no clock edge, and no result after release.
- REQ-034 Basic add: WIDTH=8, DIGIT=1, a=0x3C, b=0x05, cin=0 -> out_valid rises 8 edges after accept with sum=0x41, carry=0.
- REQ-035 Wrap-around: a=0xFF, b=0x01, cin=0 gives sum=0x00, carry=1; and a=0xFF, b=0xFF, cin=1 gives sum=0xFF, carry=1.
- REQ-036 Backpressure: hold out_ready=0 for 20 cycles in DONE -> sum/carry stable and in_ready=0 throughout; assert out_ready -> IDLE next edge, in_ready=1.
- REQ-037 Ignored input: toggle in_valid, a and b while BUSY -> result unaffected; new operands are accepted only after the DONE handshake.
- REQ-038 Random sweep: 1000 random {a,b,cin} per configuration (WIDTH,DIGIT) = (8,1), (8,4), (16,16), (13,1), with random out_ready stalls -> every result equals golden {carry,sum}=a+b+cin; print a pass/fail banner and stop on the first mismatch.
